flash_prog_seq: RTL and testbench

FLASH_PROG_SEQ -- requirements
Module: flash_prog_seq

---
 rtl/flash_pkg.sv | 34 +++
 rtl/flash_chunk_buf.sv | 42 ++++
 rtl/flash_prog_seq.sv | 210 +++++++++++++++++++++
 tb/tb_flash_prog_seq.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared flash definitions: command opcodes, programming-sequencer state encoding
// and the chunk-size helper used by the sequencer.
package flash_pkg;

  localparam logic [7:0] CMD_WR = 8'h00;
  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_SE = 8'h02;
  localparam logic [7:0] CMD_BE = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHK     = 3'd1,
    ST_SE_REQ  = 3'd2,
    ST_SE_WAIT = 3'd3,
    ST_FILL    = 3'd4,
    ST_WR_REQ  = 3'd5,
    ST_WR_WAIT = 3'd6,
    ST_FIN     = 3'd7
  } seq_state_t;

  // Bytes in the next write: never past the end of the job, the command limit or the 256-byte page.
  function automatic logic [8:0] chunk_len(input logic [23:0] rem,
                                           input logic [7:0]  addr_lo,
                                           input logic [8:0]  max_num);
    logic [8:0] k;
    logic [8:0] page_left;
    page_left = 9'd256 - {1'b0, addr_lo};
    k = max_num;
    if (page_left < k) k = page_left;
    if (rem < {15'd0, k}) k = rem[8:0];
    return k;
  endfunction

endpackage

// File: rtl/flash_chunk_buf.sv
// Byte-lane assembly buffer: bytes land in consecutive lanes starting at lane 0,
// unwritten lanes stay zero until the next clear.
module flash_chunk_buf #(
  parameter int C_MAX_BYTE_NUM = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_clr,
  input  logic                              i_wr,
  input  logic [7:0]                        i_data,
  output logic [$clog2(C_MAX_BYTE_NUM):0]   o_idx,
  output logic [C_MAX_BYTE_NUM*8-1:0]       o_data
);

  localparam int CW = $clog2(C_MAX_BYTE_NUM) + 1;

  logic [CW-1:0] r_idx;
  logic [7:0]    r_lane [C_MAX_BYTE_NUM];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      for (int i = 0; i < C_MAX_BYTE_NUM; i++) r_lane[i] <= 8'd0;
    end else if (i_clr) begin
      r_idx <= '0;
      for (int i = 0; i < C_MAX_BYTE_NUM; i++) r_lane[i] <= 8'd0;
    end else if (i_wr) begin
      for (int i = 0; i < C_MAX_BYTE_NUM; i++) begin
        if (r_idx == CW'(i)) r_lane[i] <= i_data;
      end
      r_idx <= r_idx + CW'(1);
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < C_MAX_BYTE_NUM; i++) o_data[8*i +: 8] = r_lane[i];
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/flash_prog_seq.sv
// Flash programming sequencer: erases each touched sector, then streams bytes into
// page-bounded write commands for the flash controller, with a per-command watchdog.
module flash_prog_seq
  import flash_pkg::*;
#(
  parameter int C_MAX_BYTE_NUM    = 4,
  parameter int C_SECTOR_BITS     = 16,
  parameter int C_TIMEOUT_CLK_NUM = 24'hFFFFFF
) (
  input  logic                              SYS_CLK_I,
  input  logic                              SYS_RST_N_I,
  input  logic                              START_I,
  input  logic [23:0]                       BASE_ADDR_I,
  input  logic [23:0]                       LEN_I,
  input  logic [7:0]                        S_DATA_I,
  input  logic                              S_VALID_I,
  output logic                              S_READY_O,
  output logic [7:0]                        F_CMD_O,
  output logic                              F_START_O,
  output logic [23:0]                       F_ADDR_O,
  output logic [$clog2(C_MAX_BYTE_NUM):0]   F_BYTE_NUM_O,
  output logic [C_MAX_BYTE_NUM*8-1:0]       F_PDATA_O,
  input  logic                              F_BUSY_I,
  input  logic                              F_FINISH_I,
  output logic                              BUSY_O,
  output logic                              DONE_O,
  output logic                              ERR_O,
  output logic [2:0]                        DBG_STATE_O
);

  localparam int          CW        = $clog2(C_MAX_BYTE_NUM) + 1;
  localparam logic [8:0]  MAXN      = 9'(C_MAX_BYTE_NUM);
  localparam logic [23:0] SECT_MASK = ~((24'd1 << C_SECTOR_BITS) - 24'd1);
  localparam logic [23:0] WD_LAST   = 24'(C_TIMEOUT_CLK_NUM - 1);

  seq_state_t                  r_state;
  logic                        r_start_d;
  logic [23:0]                 r_addr;
  logic [23:0]                 r_rem;
  logic                        r_first;
  logic [23:0]                 r_wdog;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_s_ready;
  logic                        r_f_start;
  logic [7:0]                  r_f_cmd;
  logic [23:0]                 r_f_addr;
  logic [CW-1:0]               r_f_num;
  logic [C_MAX_BYTE_NUM*8-1:0] r_f_pdata;

  logic                        w_start_edge;
  logic                        w_xfer;
  logic [8:0]                  w_k;
  logic [CW-1:0]               w_k_cw;
  logic [CW-1:0]               w_fill_cnt;
  logic                        w_last;
  logic                        w_sect_zero;
  logic                        w_wd_expire;
  logic                        w_buf_clr;
  logic                        w_buf_wr;
  logic [C_MAX_BYTE_NUM*8-1:0] w_buf_data;

  assign w_start_edge = START_I & ~r_start_d;
  assign w_xfer       = S_VALID_I & r_s_ready;
  assign w_k          = chunk_len(r_rem, r_addr[7:0], MAXN);
  assign w_k_cw       = w_k[CW-1:0];
  assign w_last       = w_xfer && ((w_fill_cnt + CW'(1)) == w_k_cw);
  assign w_sect_zero  = (r_addr & ~SECT_MASK) == 24'd0;
  assign w_wd_expire  = (r_wdog == WD_LAST);
  // The buffer is emptied once its contents are captured into the write command,
  // so F_PDATA_O stays stable while the next chunk is assembled.
  assign w_buf_clr    = ((r_state == ST_IDLE) && w_start_edge) ||
                        ((r_state == ST_WR_REQ) && !F_BUSY_I);
  assign w_buf_wr     = (r_state == ST_FILL) && w_xfer;

  flash_chunk_buf #(
    .C_MAX_BYTE_NUM(C_MAX_BYTE_NUM)
  ) u_chunk_buf (
    .i_clk   (SYS_CLK_I),
    .i_rst_n (SYS_RST_N_I),
    .i_clr   (w_buf_clr),
    .i_wr    (w_buf_wr),
    .i_data  (S_DATA_I),
    .o_idx   (w_fill_cnt),
    .o_data  (w_buf_data)
  );

  always_ff @(posedge SYS_CLK_I or negedge SYS_RST_N_I) begin
    if (!SYS_RST_N_I) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_addr    <= '0;
      r_rem     <= '0;
      r_first   <= 1'b0;
      r_wdog    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_s_ready <= 1'b0;
      r_f_start <= 1'b0;
      r_f_cmd   <= '0;
      r_f_addr  <= '0;
      r_f_num   <= '0;
      r_f_pdata <= '0;
    end else begin
      r_start_d <= START_I;
      r_f_start <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_addr  <= BASE_ADDR_I;
            r_rem   <= LEN_I;
            r_first <= 1'b1;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (r_rem == 24'd0) begin
            r_state <= ST_FIN;
          end else if (r_first || w_sect_zero) begin
            r_first <= 1'b0;
            r_state <= ST_SE_REQ;
          end else begin
            r_s_ready <= 1'b1;
            r_state   <= ST_FILL;
          end
        end
        ST_SE_REQ: begin
          if (!F_BUSY_I) begin
            r_f_cmd   <= CMD_SE;
            r_f_addr  <= r_addr & SECT_MASK;
            r_f_start <= 1'b1;
            r_wdog    <= '0;
            r_state   <= ST_SE_WAIT;
          end
        end
        ST_SE_WAIT: begin
          if (F_FINISH_I) begin
            r_wdog    <= '0;
            r_s_ready <= 1'b1;
            r_state   <= ST_FILL;
          end else if (w_wd_expire) begin
            r_wdog  <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 24'd1;
          end
        end
        ST_FILL: begin
          if (w_last) begin
            r_s_ready <= 1'b0;
            r_state   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!F_BUSY_I) begin
            r_f_cmd   <= CMD_WR;
            r_f_addr  <= r_addr;
            r_f_num   <= w_k_cw;
            r_f_pdata <= w_buf_data;
            r_f_start <= 1'b1;
            r_wdog    <= '0;
            r_state   <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (F_FINISH_I) begin
            r_addr  <= r_addr + {15'd0, w_k};
            r_rem   <= r_rem - {15'd0, w_k};
            r_wdog  <= '0;
            r_state <= ST_CHK;
          end else if (w_wd_expire) begin
            r_wdog  <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 24'd1;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign S_READY_O    = r_s_ready;
  assign F_CMD_O      = r_f_cmd;
  assign F_START_O    = r_f_start;
  assign F_ADDR_O     = r_f_addr;
  assign F_BYTE_NUM_O = r_f_num;
  assign F_PDATA_O    = r_f_pdata;
  assign BUSY_O       = r_busy;
  assign DONE_O       = r_done;
  assign ERR_O        = r_err;
  assign DBG_STATE_O  = r_state;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq with a small flash-controller model that logs
// every command it is handed.
module tb_flash_prog_seq;

  logic        SYS_CLK_I = 1'b0;
  logic        SYS_RST_N_I;
  logic        START_I;
  logic [23:0] BASE_ADDR_I;
  logic [23:0] LEN_I;
  logic [7:0]  S_DATA_I;
  logic        S_VALID_I;
  logic        S_READY_O;
  logic [7:0]  F_CMD_O;
  logic        F_START_O;
  logic [23:0] F_ADDR_O;
  logic [2:0]  F_BYTE_NUM_O;
  logic [31:0] F_PDATA_O;
  logic        F_BUSY_I;
  logic        F_FINISH_I;
  logic        BUSY_O;
  logic        DONE_O;
  logic        ERR_O;
  logic [2:0]  DBG_STATE_O;

  int checks = 0;
  int errors = 0;

  flash_prog_seq #(
    .C_MAX_BYTE_NUM(4),
    .C_SECTOR_BITS(16),
    .C_TIMEOUT_CLK_NUM(100)
  ) dut (
    .SYS_CLK_I    (SYS_CLK_I),
    .SYS_RST_N_I  (SYS_RST_N_I),
    .START_I      (START_I),
    .BASE_ADDR_I  (BASE_ADDR_I),
    .LEN_I        (LEN_I),
    .S_DATA_I     (S_DATA_I),
    .S_VALID_I    (S_VALID_I),
    .S_READY_O    (S_READY_O),
    .F_CMD_O      (F_CMD_O),
    .F_START_O    (F_START_O),
    .F_ADDR_O     (F_ADDR_O),
    .F_BYTE_NUM_O (F_BYTE_NUM_O),
    .F_PDATA_O    (F_PDATA_O),
    .F_BUSY_I     (F_BUSY_I),
    .F_FINISH_I   (F_FINISH_I),
    .BUSY_O       (BUSY_O),
    .DONE_O       (DONE_O),
    .ERR_O        (ERR_O),
    .DBG_STATE_O  (DBG_STATE_O)
  );

  // Clock
  always #5 SYS_CLK_I = ~SYS_CLK_I;

  // Flash controller model: busy for three cycles per command, then FINISH
  // unless withheld; checks command fields hold steady while outstanding.
  logic [7:0]  lg_cmd  [$];
  logic [23:0] lg_addr [$];
  logic [2:0]  lg_num  [$];
  logic [31:0] lg_data [$];
  int          start_cnt = 0;
  int          fl_cnt    = 0;
  logic        withhold  = 1'b0;

  always @(negedge SYS_CLK_I) begin
    F_FINISH_I = 1'b0;
    if (!SYS_RST_N_I) begin
      F_BUSY_I = 1'b0;
      fl_cnt   = 0;
    end else if (F_START_O) begin
      start_cnt++;
      lg_cmd.push_back(F_CMD_O);
      lg_addr.push_back(F_ADDR_O);
      lg_num.push_back(F_BYTE_NUM_O);
      lg_data.push_back(F_PDATA_O);
      F_BUSY_I = 1'b1;
      fl_cnt   = 3;
    end else if (fl_cnt != 0) begin
      checks++;
      if (F_CMD_O !== lg_cmd[$] || F_ADDR_O !== lg_addr[$] ||
          F_BYTE_NUM_O !== lg_num[$] || F_PDATA_O !== lg_data[$]) begin
        errors++;
        $display("FAIL cmd_stable got cmd=%0h addr=%0h num=%0d data=%0h exp cmd=%0h addr=%0h num=%0d data=%0h",
                 F_CMD_O, F_ADDR_O, F_BYTE_NUM_O, F_PDATA_O, lg_cmd[$], lg_addr[$], lg_num[$], lg_data[$]);
      end
      fl_cnt--;
      if (fl_cnt == 0) begin
        F_BUSY_I = 1'b0;
        if (!withhold) F_FINISH_I = 1'b1;
      end
    end
  end

  // Driver tasks (all entered and left at a negedge)
  task automatic clear_log();
    lg_cmd.delete();
    lg_addr.delete();
    lg_num.delete();
    lg_data.delete();
  endtask

  task automatic start_job(input logic [23:0] base, input logic [23:0] len);
    BASE_ADDR_I = base;
    LEN_I       = len;
    START_I     = 1'b1;
    @(negedge SYS_CLK_I);
    START_I     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    S_VALID_I = 1'b1;
    S_DATA_I  = b;
    while (!S_READY_O && t < 2000) begin
      @(negedge SYS_CLK_I);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout got ready=%0b after %0d cycles exp ready=1", S_READY_O, t);
    end
    @(negedge SYS_CLK_I);
    S_VALID_I = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!DONE_O && t < 5000) begin
      @(negedge SYS_CLK_I);
      t++;
    end
    checks++;
    if (!DONE_O) begin
      errors++;
      $display("FAIL done_timeout got done=%0b exp done=1 within 5000 cycles", DONE_O);
    end
  endtask

  task automatic run_job(input logic [23:0] base, input logic [23:0] len, input logic [7:0] b0);
    clear_log();
    start_job(base, len);
    for (int i = 0; i < int'(len); i++) send_byte(b0 + 8'(i));
    wait_done();
  endtask

  // Tests
  task automatic test_reset();
    checks++;
    if ({S_READY_O, F_START_O, BUSY_O, DONE_O, ERR_O} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready/start/busy/done/err=%05b exp 00000",
               {S_READY_O, F_START_O, BUSY_O, DONE_O, ERR_O});
    end
    checks++;
    if (F_CMD_O !== 8'h0 || F_ADDR_O !== 24'h0 || F_BYTE_NUM_O !== 3'd0 || F_PDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got cmd=%0h addr=%0h num=%0d data=%0h exp all 0",
               F_CMD_O, F_ADDR_O, F_BYTE_NUM_O, F_PDATA_O);
    end
    checks++;
    if (DBG_STATE_O !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", DBG_STATE_O);
    end
  endtask

  task automatic test_single();
    logic [7:0]  ec [2] = '{8'h02, 8'h00};
    logic [23:0] ea [2] = '{24'h010000, 24'h010000};
    run_job(24'h010000, 24'd4, 8'h11);
    checks++;
    if (lg_cmd.size() != 2) begin
      errors++;
      $display("FAIL single_count got %0d exp 2", lg_cmd.size());
    end
    for (int i = 0; i < 2 && i < lg_cmd.size(); i++) begin
      checks++;
      if (lg_cmd[i] !== ec[i] || lg_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL single_cmd[%0d] got cmd=%0h addr=%0h exp cmd=%0h addr=%0h", i, lg_cmd[i], lg_addr[i], ec[i], ea[i]);
      end
    end
    if (lg_cmd.size() == 2) begin
      checks++;
      if (lg_num[1] !== 3'd4 || lg_data[1] !== 32'h14131211) begin
        errors++;
        $display("FAIL single_wr got num=%0d data=%0h exp num=4 data=14131211", lg_num[1], lg_data[1]);
      end
    end
    @(negedge SYS_CLK_I);
    checks++;
    if (BUSY_O !== 1'b0 || DONE_O !== 1'b0 || ERR_O !== 1'b0) begin
      errors++;
      $display("FAIL single_end got busy=%0b done=%0b err=%0b exp 0 0 0", BUSY_O, DONE_O, ERR_O);
    end
  endtask

  task automatic test_page_cross();
    logic [7:0]  ec [3] = '{8'h02, 8'h00, 8'h00};
    logic [23:0] ea [3] = '{24'h010000, 24'h0100FE, 24'h010100};
    logic [2:0]  en [3] = '{3'd0, 3'd2, 3'd2};
    logic [31:0] ed [3] = '{32'h0, 32'h0000A2A1, 32'h0000A4A3};
    clear_log();
    start_job(24'h0100FE, 24'd4);
    // A second START edge while busy must not restart or disturb the job.
    @(negedge SYS_CLK_I);
    BASE_ADDR_I = 24'h777700;
    START_I     = 1'b1;
    @(negedge SYS_CLK_I);
    START_I     = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i));
    wait_done();
    checks++;
    if (lg_cmd.size() != 3) begin
      errors++;
      $display("FAIL page_count got %0d exp 3", lg_cmd.size());
    end
    for (int i = 0; i < 3 && i < lg_cmd.size(); i++) begin
      checks++;
      if (lg_cmd[i] !== ec[i] || lg_addr[i] !== ea[i] ||
          (ec[i] == 8'h00 && (lg_num[i] !== en[i] || lg_data[i] !== ed[i]))) begin
        errors++;
        $display("FAIL page_cmd[%0d] got cmd=%0h addr=%0h num=%0d data=%0h exp cmd=%0h addr=%0h num=%0d data=%0h",
                 i, lg_cmd[i], lg_addr[i], lg_num[i], lg_data[i], ec[i], ea[i], en[i], ed[i]);
      end
    end
  endtask

  task automatic test_sector_cross();
    logic [7:0]  ec [4] = '{8'h02, 8'h00, 8'h02, 8'h00};
    logic [23:0] ea [4] = '{24'h010000, 24'h01FFFE, 24'h020000, 24'h020000};
    logic [2:0]  en [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
    logic [31:0] ed [4] = '{32'h0, 32'h0000B2B1, 32'h0, 32'h0000B4B3};
    run_job(24'h01FFFE, 24'd4, 8'hB1);
    checks++;
    if (lg_cmd.size() != 4) begin
      errors++;
      $display("FAIL sector_count got %0d exp 4", lg_cmd.size());
    end
    for (int i = 0; i < 4 && i < lg_cmd.size(); i++) begin
      checks++;
      if (lg_cmd[i] !== ec[i] || lg_addr[i] !== ea[i] ||
          (ec[i] == 8'h00 && (lg_num[i] !== en[i] || lg_data[i] !== ed[i]))) begin
        errors++;
        $display("FAIL sector_cmd[%0d] got cmd=%0h addr=%0h num=%0d data=%0h exp cmd=%0h addr=%0h num=%0d data=%0h",
                 i, lg_cmd[i], lg_addr[i], lg_num[i], lg_data[i], ec[i], ea[i], en[i], ed[i]);
      end
    end
  endtask

  task automatic test_multi_chunk();
    logic [7:0]  ec [3] = '{8'h02, 8'h00, 8'h00};
    logic [23:0] ea [3] = '{24'h050000, 24'h050000, 24'h050004};
    logic [2:0]  en [3] = '{3'd0, 3'd4, 3'd2};
    logic [31:0] ed [3] = '{32'h0, 32'h13121110, 32'h00001514};
    clear_log();
    start_job(24'h050000, 24'd6);
    checks++;
    if (ERR_O !== 1'b0 || BUSY_O !== 1'b1) begin
      errors++;
      $display("FAIL multi_start got err=%0b busy=%0b exp err=0 busy=1", ERR_O, BUSY_O);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
    wait_done();
    checks++;
    if (lg_cmd.size() != 3) begin
      errors++;
      $display("FAIL multi_count got %0d exp 3", lg_cmd.size());
    end
    for (int i = 0; i < 3 && i < lg_cmd.size(); i++) begin
      checks++;
      if (lg_cmd[i] !== ec[i] || lg_addr[i] !== ea[i] ||
          (ec[i] == 8'h00 && (lg_num[i] !== en[i] || lg_data[i] !== ed[i]))) begin
        errors++;
        $display("FAIL multi_cmd[%0d] got cmd=%0h addr=%0h num=%0d data=%0h exp cmd=%0h addr=%0h num=%0d data=%0h",
                 i, lg_cmd[i], lg_addr[i], lg_num[i], lg_data[i], ec[i], ea[i], en[i], ed[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    int sc = start_cnt;
    BASE_ADDR_I = 24'h060000;
    LEN_I       = 24'd0;
    START_I     = 1'b1;
    @(negedge SYS_CLK_I);
    START_I = 1'b0;
    checks++;
    if (BUSY_O !== 1'b1 || DONE_O !== 1'b0) begin
      errors++;
      $display("FAIL len0_c1 got busy=%0b done=%0b exp busy=1 done=0", BUSY_O, DONE_O);
    end
    @(negedge SYS_CLK_I);
    checks++;
    if (DONE_O !== 1'b0) begin
      errors++;
      $display("FAIL len0_c2 got done=%0b exp 0", DONE_O);
    end
    @(negedge SYS_CLK_I);
    checks++;
    if (DONE_O !== 1'b1 || BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL len0_done got done=%0b busy=%0b exp done=1 busy=0", DONE_O, BUSY_O);
    end
    @(negedge SYS_CLK_I);
    checks++;
    if (DONE_O !== 1'b0 || start_cnt != sc) begin
      errors++;
      $display("FAIL len0_after got done=%0b starts=%0d exp done=0 starts=%0d", DONE_O, start_cnt, sc);
    end
  endtask

  task automatic test_timeout();
    int t = 0;
    int n = 0;
    clear_log();
    withhold = 1'b1;
    start_job(24'h030000, 24'd4);
    while (!F_START_O && t < 50) begin
      @(negedge SYS_CLK_I);
      t++;
    end
    while (!ERR_O && n < 300) begin
      @(negedge SYS_CLK_I);
      n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles exp 100", n);
    end
    checks++;
    if (ERR_O !== 1'b1 || DONE_O !== 1'b1 || BUSY_O !== 1'b0 || lg_cmd.size() != 1) begin
      errors++;
      $display("FAIL timeout_flags got err=%0b done=%0b busy=%0b cmds=%0d exp 1 1 0 1",
               ERR_O, DONE_O, BUSY_O, lg_cmd.size());
    end
    repeat (3) @(negedge SYS_CLK_I);
    checks++;
    if (ERR_O !== 1'b1 || DONE_O !== 1'b0 || DBG_STATE_O !== 3'd0) begin
      errors++;
      $display("FAIL timeout_sticky got err=%0b done=%0b state=%0d exp err=1 done=0 state=0",
               ERR_O, DONE_O, DBG_STATE_O);
    end
    withhold = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int sc;
    clear_log();
    start_job(24'h040000, 24'd4);
    send_byte(8'h55);
    send_byte(8'h66);
    checks++;
    if (S_READY_O !== 1'b1 || DBG_STATE_O !== 3'd4) begin
      errors++;
      $display("FAIL midfill_pre got ready=%0b state=%0d exp ready=1 state=4", S_READY_O, DBG_STATE_O);
    end
    SYS_RST_N_I = 1'b0;
    #1;
    checks++;
    if ({S_READY_O, F_START_O, BUSY_O, DONE_O, ERR_O} !== 5'b0 || DBG_STATE_O !== 3'd0 ||
        F_CMD_O !== 8'h0 || F_ADDR_O !== 24'h0 || F_BYTE_NUM_O !== 3'd0 || F_PDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL midfill_reset got ctrl=%05b state=%0d cmd=%0h addr=%0h num=%0d data=%0h exp all 0",
               {S_READY_O, F_START_O, BUSY_O, DONE_O, ERR_O}, DBG_STATE_O, F_CMD_O, F_ADDR_O, F_BYTE_NUM_O, F_PDATA_O);
    end
    sc = start_cnt;
    repeat (3) @(negedge SYS_CLK_I);
    SYS_RST_N_I = 1'b1;
    repeat (2) @(negedge SYS_CLK_I);
    checks++;
    if (start_cnt != sc || BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL midfill_quiet got starts=%0d busy=%0b exp starts=%0d busy=0", start_cnt, BUSY_O, sc);
    end
    run_job(24'h040004, 24'd4, 8'hC1);
    checks++;
    if (lg_cmd.size() != 2) begin
      errors++;
      $display("FAIL midfill_count got %0d exp 2", lg_cmd.size());
    end else begin
      checks++;
      if (lg_cmd[0] !== 8'h02 || lg_addr[0] !== 24'h040000 || lg_cmd[1] !== 8'h00 ||
          lg_addr[1] !== 24'h040004 || lg_num[1] !== 3'd4 || lg_data[1] !== 32'hC4C3C2C1) begin
        errors++;
        $display("FAIL midfill_next got se=%0h@%0h wr=%0h@%0h num=%0d data=%0h exp se=2@40000 wr=0@40004 num=4 data=c4c3c2c1",
                 lg_cmd[0], lg_addr[0], lg_cmd[1], lg_addr[1], lg_num[1], lg_data[1]);
      end
    end
  endtask

  // Sequence and report
  initial begin
    SYS_RST_N_I = 1'b0;
    START_I     = 1'b0;
    BASE_ADDR_I = 24'h0;
    LEN_I       = 24'h0;
    S_DATA_I    = 8'h0;
    S_VALID_I   = 1'b0;
    F_BUSY_I    = 1'b0;
    F_FINISH_I  = 1'b0;
    repeat (3) @(negedge SYS_CLK_I);
    test_reset();
    SYS_RST_N_I = 1'b1;
    repeat (2) @(negedge SYS_CLK_I);
    test_single();
    test_page_cross();
    test_sector_cross();
    test_len_zero();
    test_timeout();
    test_multi_chunk();
    test_reset_mid_fill();
    repeat (3) @(negedge SYS_CLK_I);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
